moving_average_filter: RTL and testbench

Four-channel moving-average denoiser that sits directly downstream of the AWGN channel stage. It consumes the four 16-bit noisy sample streams and produces four smoothed streams. Each output is the mean of the last 2^LOG2_N accepted samples on that channel, computed with a running sum over a circular delay buffer. A bypass mode passes samples straight through while the buffers stay live, so the filter can be re-enabled without a glitch.

---
 rtl/moving_average_filter.sv | 159 +++++++++++++++
 tb/tb_moving_average_filter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_filter.sv
// Purpose: four-channel moving-average denoiser (window N = 2^LOG2_N) with a glitch-free bypass mode.
// Latency: one cycle, so a sample accepted at edge k is visible on data_out/out_valid in cycle k+1.
// Backpressure: none; sample_en is a strobe, and with it low all state and outputs hold.
module moving_average_filter #(
  parameter int LOG2_N = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        bypass,
  input  logic [15:0] data_in1,
  input  logic [15:0] data_in2,
  input  logic [15:0] data_in3,
  input  logic [15:0] data_in4,
  output logic [15:0] data_out1,
  output logic [15:0] data_out2,
  output logic [15:0] data_out3,
  output logic [15:0] data_out4,
  output logic        out_valid,
  output logic        window_full
);

  localparam int NCH = 4;
  localparam int N   = 1 << LOG2_N;
  // The running sum of N 16-bit samples needs LOG2_N guard bits and cannot overflow.
  localparam int SW  = 16 + LOG2_N;
  localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N + 1)'(N);

  typedef logic [NCH-1:0][15:0] quad_t;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Channel bundles: index 0 is channel 1.
  quad_t din;
  quad_t dout_q;

  assign din = {data_in4, data_in3, data_in2, data_in1};

  assign data_out1 = dout_q[0];
  assign data_out2 = dout_q[1];
  assign data_out3 = dout_q[2];
  assign data_out4 = dout_q[3];

  // Shared control state.
  state_t            state;
  state_t            state_nxt;
  logic [LOG2_N-1:0] wr_ptr;
  logic [LOG2_N:0]   fill_cnt;
  logic [LOG2_N:0]   fill_nxt;
  logic              out_valid_nxt;

  // Sign-extend a 16-bit sample to the running-sum width.
  function automatic logic signed [SW-1:0] sext(input logic [15:0] v);
    return $signed({{LOG2_N{v[15]}}, v});
  endfunction

  // Next-state, fill-count and out_valid decode; every output defaulted first.
  always_comb begin
    state_nxt     = state;
    fill_nxt      = fill_cnt;
    out_valid_nxt = 1'b0;
    if (sample_en) begin
      // Saturate at N so the counter never wraps back into warm-up.
      if (fill_cnt != FILL_MAX) begin
        fill_nxt = fill_cnt + 1'b1;
      end
      case (state)
        WARMUP: begin
          if (fill_nxt == FILL_MAX) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = WARMUP;
        end
      endcase
      // Using the next state lets the N-th sample itself be flagged valid.
      out_valid_nxt = bypass || (state_nxt == RUN);
    end
  end

  // State register, fill counter and write pointer; reset starts a fresh warm-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WARMUP;
      fill_cnt <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      if (sample_en) begin
        // N is a power of two, so the natural wrap from N-1 to 0 is free.
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // out_valid is a registered single-cycle pulse per qualifying accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid_nxt;
    end
  end

  // The state flop is the window_full register; RUN is only left through reset.
  assign window_full = (state == RUN);

  // Per-channel delay line, running sum and output register.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [15:0]          dly_mem [N];
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] sum_nxt;
    logic [15:0]          old_smp;
    logic [15:0]          filt_val;
    logic [15:0]          dout_r;

    // Drop the oldest sample and add the newest; a zeroed buffer makes warm-up exact.
    always_comb begin
      old_smp  = dly_mem[wr_ptr];
      sum_nxt  = sum_q + sext(din[c]) - sext(old_smp);
      // Arithmetic shift floors toward negative infinity; the mean always fits 16 bits.
      filt_val = 16'(sum_nxt >>> LOG2_N);
    end

    // Buffer and sum advance on every accepted sample, in bypass or not, so that
    // leaving bypass immediately yields a correct average.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          dly_mem[i[LOG2_N-1:0]] <= '0;
        end
        sum_q <= '0;
      end else if (sample_en) begin
        dly_mem[wr_ptr] <= din[c];
        sum_q           <= sum_nxt;
      end
    end

    // Registered output mux; bypass only matters on accepted samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_r <= '0;
      end else if (sample_en) begin
        dout_r <= bypass ? din[c] : filt_val;
      end
    end

    assign dout_q[c] = dout_r;
  end

endmodule

// File: tb/tb_moving_average_filter.sv
module tb_moving_average_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic        bypass = 1'b0;
  logic [15:0] data_in1 = '0;
  logic [15:0] data_in2 = '0;
  logic [15:0] data_in3 = '0;
  logic [15:0] data_in4 = '0;
  logic [15:0] data_out1;
  logic [15:0] data_out2;
  logic [15:0] data_out3;
  logic [15:0] data_out4;
  logic        out_valid;
  logic        window_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moving_average_filter #(.LOG2_N(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .bypass      (bypass),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .data_in3    (data_in3),
    .data_in4    (data_in4),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .data_out3   (data_out3),
    .data_out4   (data_out4),
    .out_valid   (out_valid),
    .window_full (window_full)
  );

  typedef struct packed {
    logic [3:0][15:0] d;
    logic             v;
    logic             wf;
  } exp_t;

  logic [3:0][15:0] dout;
  assign dout = {data_out4, data_out3, data_out2, data_out1};

  // Reference model: last four samples per channel (newest at index 0) and a fill count.
  exp_t sb_q[$];
  int   win [4][4];
  int   fill_m;

  task automatic model_clear();
    fill_m = 0;
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < 4; k++)
        win[ch][k] = 0;
  endtask

  // Drive one cycle of stimulus, update the model on an accepted sample, return #1 after the edge.
  task automatic put(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] d, input logic byp, input logic en, input logic rst);
    logic [3:0][15:0] x;
    exp_t e;
    int s;
    x = {d, c, b, a};
    data_in1 = a; data_in2 = b; data_in3 = c; data_in4 = d;
    bypass = byp; sample_en = en; reset = rst;
    if (rst) begin
      model_clear();
    end else if (en) begin
      if (fill_m < 4) fill_m++;
      e.wf = (fill_m == 4);
      e.v  = byp || e.wf;
      for (int ch = 0; ch < 4; ch++) begin
        for (int k = 3; k > 0; k--) win[ch][k] = win[ch][k-1];
        win[ch][0] = int'($signed(x[ch]));
        s = win[ch][0] + win[ch][1] + win[ch][2] + win[ch][3];
        e.d[ch] = byp ? x[ch] : 16'(s >>> 2);
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: after every edge, outputs must match the popped expectation,
  // the reset values, or hold with out_valid low.
  bit               acc_flag = 1'b0;
  bit               rst_flag = 1'b0;
  logic [3:0][15:0] hold_d = '0;
  logic             hold_wf = 1'b0;
  exp_t             mon_e;

  always @(posedge clk) begin
    acc_flag <= sample_en && !reset;
    rst_flag <= reset;
  end

  always @(negedge clk) begin
    if (rst_flag) begin
      checks++;
      if ({dout, out_valid, window_full} !== 66'h0) begin
        failures++;
        $display("FAIL sb_reset: got dout=%h v=%b wf=%b want all zero", dout, out_valid, window_full);
      end
      hold_d = '0;
      hold_wf = 1'b0;
    end else if (acc_flag) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: output produced with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        if ({dout, out_valid, window_full} !== mon_e) begin
          failures++;
          $display("FAIL sb_sample: got dout=%h v=%b wf=%b want dout=%h v=%b wf=%b",
                   dout, out_valid, window_full, mon_e.d, mon_e.v, mon_e.wf);
        end
        hold_d = mon_e.d;
        hold_wf = mon_e.wf;
      end
    end else begin
      checks++;
      if (dout !== hold_d || out_valid !== 1'b0 || window_full !== hold_wf) begin
        failures++;
        $display("FAIL sb_hold: got dout=%h v=%b wf=%b want dout=%h v=0 wf=%b",
                 dout, out_valid, window_full, hold_d, hold_wf);
      end
    end
  end

  task automatic test_reset();
    put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      put(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (dout !== '0 || out_valid !== 1'b0 || window_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got dout=%h v=%b wf=%b want 0/0/0", i, dout, out_valid, window_full);
      end
    end
  endtask

  task automatic test_warmup_step();
    int smp [5] = '{4, 8, 12, 16, 20};
    int avg [5] = '{1, 3, 6, 10, 14};
    logic vld [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      put(16'(smp[i]), 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (data_out1 !== 16'(avg[i]) || out_valid !== vld[i] || window_full !== vld[i]) begin
        failures++;
        $display("FAIL warmup_step[%0d]: got out1=%0d v=%b wf=%b want out1=%0d v=%b wf=%b",
                 i, data_out1, out_valid, window_full, avg[i], vld[i], vld[i]);
      end
    end
  endtask

  task automatic test_const_wrap();
    put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      put(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0);
      if (i >= 3) begin
        checks++;
        if (dout !== {4{16'h0100}} || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL const_wrap[%0d]: got dout=%h v=%b want 0100 x4 v=1", i, dout, out_valid);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] pat [2] = '{16'h7FFF, 16'h8000};
    for (int p = 0; p < 2; p++) begin
      put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) put(pat[p], pat[p], pat[p], pat[p], 1'b0, 1'b1, 1'b0);
      checks++;
      if (dout !== {4{pat[p]}} || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL extreme_%h: got dout=%h v=%b want %h x4 v=1", pat[p], dout, out_valid, pat[p]);
      end
    end
    put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    put(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dout !== {4{16'hFFFF}} || window_full !== 1'b1) begin
      failures++;
      $display("FAIL floor_neg: got dout=%h wf=%b want FFFF x4 wf=1", dout, window_full);
    end
  endtask

  task automatic test_bypass_gaps();
    put(16'h00A1, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (data_out1 !== 16'h00A1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bypass_pass: got out1=%h v=%b want 00A1 v=1", data_out1, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      put(16'h5555, 16'h1111, 16'h2222, 16'h3333, 1'(i), 1'b0, 1'b0);
      checks++;
      if (data_out1 !== 16'h00A1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL gap_hold[%0d]: got out1=%h v=%b want 00A1 v=0", i, data_out1, out_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      put(16'h00A1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      put(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (data_out1 !== 16'h00A1 || window_full !== 1'b1) begin
      failures++;
      $display("FAIL bypass_exit: got out1=%h wf=%b want 00A1 wf=1", data_out1, window_full);
    end
  endtask

  task automatic test_reset_mid();
    int avg [4] = '{2, 4, 6, 8};
    put(16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dout !== '0 || out_valid !== 1'b0 || window_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got dout=%h v=%b wf=%b want 0/0/0", dout, out_valid, window_full);
    end
    for (int i = 0; i < 4; i++) begin
      put(16'd8, 16'd8, 16'd8, 16'd8, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dout !== {4{16'(avg[i])}} || out_valid !== (i == 3)) begin
        failures++;
        $display("FAIL rewarm[%0d]: got dout=%h v=%b want %0d x4 v=%b", i, dout, out_valid, avg[i], (i == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      put(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || window_full !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got v=%b wf=%b want 1/1", i, out_valid, window_full);
      end
    end
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_warmup_step();
    test_const_wrap();
    test_extremes();
    test_bypass_gaps();
    test_reset_mid();
    test_back_to_back();
    put(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
